// File: rtl/seq_pkg.sv
// Shared types and constants for the song sequencer.
// Holds the FSM state encoding, the reserved note codes and the width helper
// used for the tick prescaler and gap counter.
package seq_pkg;

    // state     | meaning
    // S_IDLE    | stopped, waiting for start
    // S_FETCH_A | rom_addr/rom_song presented to the ROM
    // S_FETCH_D | ROM data valid, captured or recognised as END
    // S_NOTE    | note sounding, duration counter running
    // S_GAP     | silent ticks between notes
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_A,
        S_FETCH_D,
        S_NOTE,
        S_GAP
    } seq_state_e;

    // Reserved note codes at the widest supported note width; the top slices
    // them down to NOTE_W. END is all ones, REST is zero.
    localparam int NOTE_W_MAX = 16;
    localparam logic [NOTE_W_MAX-1:0] END_NOTE  = '1;
    localparam logic [NOTE_W_MAX-1:0] REST_NOTE = '0;

    // Default duration width, in ticks.
    localparam int DUR_W_DEF = 16;
    typedef logic [DUR_W_DEF-1:0] tick_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Tick prescaler: counts 0..TICK_DIV-1 while enabled and flags the terminal
// count as a one-cycle tick. clr forces the count back to zero.
module tick_prescaler
    import seq_pkg::*;
#(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = cnt_width(TICK_DIV);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && !clr && (cnt_q == TERM);

    // Next count: clear wins, otherwise wrap on the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: walks a song table in an external synchronous ROM and
// emits a gated note stream with start/stop/pause control, inter-note gap
// and end-of-song detection.
// Build option: define SEQ_LOOP_EN to honour the loop input; without it the
// loop input is ignored and end of song always returns to idle.
//
// state     | meaning
// S_IDLE    | stopped, waiting for start
// S_FETCH_A | rom_addr stable, ROM reading
// S_FETCH_D | ROM output captured, END detected here
// S_NOTE    | note sounding for max(dur,1) ticks
// S_GAP     | GAP_TICKS silent ticks
module song_sequencer
    import seq_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int NOTE_W    = 4,
    parameter int DUR_W     = 16,
    parameter int SONG_W    = 4,
    parameter int TICK_DIV  = 100000,
    parameter int GAP_TICKS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop,
    input  logic [SONG_W-1:0] song_sel,
    output logic [SONG_W-1:0] rom_song,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [NOTE_W-1:0] rom_note,
    input  logic [DUR_W-1:0]  rom_dur,
    output logic [NOTE_W-1:0] note_out,
    output logic              note_valid,
    output logic              playing,
    output logic              done
);

    localparam int GAP_W = cnt_width(GAP_TICKS + 1);
    localparam logic [NOTE_W-1:0] END_CODE  = END_NOTE[NOTE_W-1:0];
    localparam logic [NOTE_W-1:0] REST_CODE = REST_NOTE[NOTE_W-1:0];

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [SONG_W-1:0] song_q, song_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              done_q, done_d;
    logic              nv_q, nv_d;
    logic              play_q, play_d;
    logic              advance;
    logic              end_song;
    logic              pre_clr;
    logic              pre_en;
    logic              tick;

    // The prescaler only runs in the timed states, so it is already at zero
    // on entry to NOTE; NOTE->GAP happens on a tick, where it wraps to zero.
    assign pre_clr = !((state_q == S_NOTE) || (state_q == S_GAP));
    assign pre_en  = !pre_clr && !pause;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clr  (pre_clr),
        .en   (pre_en),
        .tick (tick)
    );

`ifndef SEQ_LOOP_EN
    logic unused_loop;
    assign unused_loop = loop;
`endif

    // Next-state and registered-output decode; stop overrides everything.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        song_d   = song_q;
        note_d   = note_q;
        dur_d    = dur_q;
        gap_d    = gap_q;
        done_d   = 1'b0;
        advance  = 1'b0;
        end_song = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH_A;
                    idx_d   = '0;
                    song_d  = song_sel;
                end
            end
            S_FETCH_A: begin
                state_d = S_FETCH_D;
            end
            S_FETCH_D: begin
                if (rom_note == END_CODE) begin
                    end_song = 1'b1;
                end else begin
                    state_d = S_NOTE;
                    note_d  = rom_note;
                    dur_d   = (rom_dur == '0) ? DUR_W'(1) : rom_dur;
                end
            end
            S_NOTE: begin
                if (tick) begin
                    dur_d = dur_q - 1'b1;
                    if (dur_q == DUR_W'(1)) begin
                        if (GAP_TICKS == 0) begin
                            advance = 1'b1;
                        end else begin
                            state_d = S_GAP;
                            gap_d   = GAP_W'(GAP_TICKS);
                        end
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    gap_d = gap_q - 1'b1;
                    if (gap_q <= GAP_W'(1)) begin
                        advance = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (advance) begin
            if (idx_q == '1) begin
                end_song = 1'b1;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = S_FETCH_A;
            end
        end

        if (end_song) begin
            done_d = 1'b1;
            idx_d  = '0;
`ifdef SEQ_LOOP_EN
            state_d = loop ? S_FETCH_A : S_IDLE;
`else
            state_d = S_IDLE;
`endif
        end

        if (stop) begin
            state_d = S_IDLE;
            idx_d   = '0;
            done_d  = 1'b0;
        end

        play_d = (state_d != S_IDLE);
        nv_d   = (state_d == S_NOTE) && (note_d != REST_CODE) && !pause;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            song_q  <= '0;
            note_q  <= '0;
            dur_q   <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
            nv_q    <= 1'b0;
            play_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            song_q  <= song_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
            nv_q    <= nv_d;
            play_q  <= play_d;
        end
    end

    assign rom_song   = song_q;
    assign rom_addr   = idx_q;
    assign note_out   = note_q;
    assign note_valid = nv_q;
    assign playing    = play_q;
    assign done       = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with TICK_DIV=4, GAP_TICKS=2, ADDR_W=2
// and a behavioural synchronous song ROM.
module tb_song_sequencer;

    localparam int ADDR_W = 2;
    localparam int NOTE_W = 4;
    localparam int DUR_W  = 16;
    localparam int SONG_W = 4;
`ifdef SEQ_LOOP_EN
    localparam int LOOP_ON = 1;
`else
    localparam int LOOP_ON = 0;
`endif

    logic              clk;
    logic              reset;
    logic              start;
    logic              stop;
    logic              pause;
    logic              loop;
    logic [SONG_W-1:0] song_sel;
    logic [SONG_W-1:0] rom_song;
    logic [ADDR_W-1:0] rom_addr;
    logic [NOTE_W-1:0] rom_note;
    logic [DUR_W-1:0]  rom_dur;
    logic [NOTE_W-1:0] note_out;
    logic              note_valid;
    logic              playing;
    logic              done;

    int nvec;
    int nmis;

    song_sequencer #(
        .ADDR_W   (ADDR_W),
        .NOTE_W   (NOTE_W),
        .DUR_W    (DUR_W),
        .SONG_W   (SONG_W),
        .TICK_DIV (4),
        .GAP_TICKS(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .loop      (loop),
        .song_sel  (song_sel),
        .rom_song  (rom_song),
        .rom_addr  (rom_addr),
        .rom_note  (rom_note),
        .rom_dur   (rom_dur),
        .note_out  (note_out),
        .note_valid(note_valid),
        .playing   (playing),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous song ROM, indexed by {song, addr}; unwritten entries are END.
    logic [NOTE_W-1:0] tbl_n [64];
    logic [DUR_W-1:0]  tbl_d [64];

    always @(posedge clk) begin
        rom_note <= tbl_n[{rom_song, rom_addr}];
        rom_dur  <= tbl_d[{rom_song, rom_addr}];
    end

    task automatic put(input int song, input int addr, input int n, input int d);
        tbl_n[song*4 + addr] = NOTE_W'(n);
        tbl_d[song*4 + addr] = DUR_W'(d);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Per-cycle observation log, sampled at negedges.
    logic              nv_log   [128];
    logic              done_log [128];
    logic              play_log [128];
    logic [NOTE_W-1:0] note_log [128];
    logic [ADDR_W-1:0] addr_log [128];
    logic [SONG_W-1:0] song_log [128];
    int nv_cnt, nv_first, nv_last, done_cnt, done_first, play_cnt;

    // Sample n cycles starting at the current negedge. Inputs driven after
    // sample k apply to the clock edge that ends cycle k.
    task automatic obs(input int n, input int pause_from, input int pause_len,
                       input int stop_at, input int start_at);
        nv_cnt = 0; nv_first = -1; nv_last = -1;
        done_cnt = 0; done_first = -1; play_cnt = 0;
        for (int k = 0; k < n; k++) begin
            nv_log[k]   = note_valid;
            done_log[k] = done;
            play_log[k] = playing;
            note_log[k] = note_out;
            addr_log[k] = rom_addr;
            song_log[k] = rom_song;
            if (note_valid === 1'b1) begin
                nv_cnt++;
                if (nv_first < 0) nv_first = k;
                nv_last = k;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_first < 0) done_first = k;
            end
            if (playing === 1'b1) play_cnt++;
            pause = (k >= pause_from) && (k < pause_from + pause_len);
            stop  = (k == stop_at);
            start = (k == start_at);
            @(negedge clk);
        end
        pause = 1'b0;
        stop  = 1'b0;
        start = 1'b0;
    endtask

    task automatic pulse_start(input int song);
        song_sel = SONG_W'(song);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        nvec = 0;
        nmis = 0;
        reset = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        pause = 1'b0;
        loop = 1'b0;
        song_sel = '0;
        for (int i = 0; i < 64; i++) begin
            tbl_n[i] = '1;
            tbl_d[i] = '0;
        end
        put(1, 0, 3, 2);
        put(2, 0, 0, 3);
        put(2, 1, 7, 1);
        put(3, 0, 9, 2);
        put(4, 0, 5, 1);
        put(4, 1, 6, 1);
        put(4, 2, 7, 1);
        put(4, 3, 8, 1);
        put(5, 0, 4, 3);
        put(5, 1, 2, 3);

        repeat (2) @(negedge clk);
        chk("reset_outputs", {rom_song, rom_addr, note_out, note_valid, playing, done}, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {note_valid, playing, done}, 0);

        // Basic note: 8 cycles sounding, 8 cycles gap, END fetch, done.
        pulse_start(1);
        obs(24, -1, 0, -1, -1);
        chk("t1_fetch_addr", addr_log[0], 0);
        chk("t1_playing", play_log[0], 1);
        chk("t1_nv_first", nv_first, 2);
        chk("t1_nv_cnt", nv_cnt, 8);
        chk("t1_note_out", note_log[5], 3);
        chk("t1_done_first", done_first, 20);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_play_at_done", play_log[20], 0);
        chk("t1_play_before_done", play_log[19], 1);

        // Rest note: silent 12 cycles, gap, then entry 1 fetched.
        pulse_start(2);
        obs(46, -1, 0, -1, -1);
        chk("t2_addr_gap", addr_log[21], 0);
        chk("t2_addr_next", addr_log[22], 1);
        chk("t2_nv_first", nv_first, 24);
        chk("t2_nv_cnt", nv_cnt, 4);
        chk("t2_note_out", note_log[25], 7);
        chk("t2_done_first", done_first, 38);

        // Pause for 20 cycles mid-note: NOTE stretches to 28 cycles.
        pulse_start(3);
        obs(45, 5, 20, -1, -1);
        chk("t3_nv_cnt", nv_cnt, 8);
        chk("t3_nv_paused", nv_log[15], 0);
        chk("t3_nv_resume", nv_log[26], 1);
        chk("t3_nv_last", nv_last, 29);
        chk("t3_note_held", note_log[15], 9);
        chk("t3_done_first", done_first, 40);

        // Stop during the gap: idle next cycle, address back to 0, no done.
        pulse_start(5);
        obs(30, -1, 0, 16, -1);
        chk("t4_play_pre", play_log[16], 1);
        chk("t4_addr_pre", addr_log[16], 0);
        chk("t4_play_stop", play_log[17], 0);
        chk("t4_addr_stop", addr_log[17], 0);
        chk("t4_nv_stop", nv_log[17], 0);
        chk("t4_done_cnt", done_cnt, 0);

        // start and stop together from idle: stays idle.
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        obs(8, -1, 0, -1, -1);
        chk("t5_start_stop_idle", play_cnt, 0);

        // Latched song select; re-start while playing is ignored.
        pulse_start(5);
        song_sel = SONG_W'(2);
        obs(50, -1, 0, -1, 28);
        chk("t6_song_latched", song_log[30], 5);
        chk("t6_second_note", note_log[30], 2);
        chk("t6_addr_entry1", addr_log[30], 1);
        chk("t6_done_first", done_first, 46);

        // Four entries, no END marker, loop high.
        loop = 1'b1;
        pulse_start(4);
        obs(60, -1, 0, -1, -1);
        chk("t7_addr_last", addr_log[42], 3);
        chk("t7_note_last", note_log[45], 8);
        chk("t7_done_first", done_first, 56);
        chk("t7_done_cnt", done_cnt, 1);
        chk("t7_addr_wrap", addr_log[56], 0);
        chk("t7_play_after", play_log[56], LOOP_ON);
        chk("t7_nv_again", nv_log[58], LOOP_ON);
        loop = 1'b0;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
        chk("t7_stopped", playing, 0);

        // Asynchronous reset mid-note.
        pulse_start(5);
        obs(6, -1, 0, -1, -1);
        chk("t8_pre_reset", {note_valid, playing}, 3);
        #2;
        reset = 1'b0;
        #1;
        chk("t8_async_reset", {rom_song, rom_addr, note_out, note_valid, playing, done}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t8_after_reset", playing, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
